// File: rtl/axis_sample_gen_mc.sv
// Multi-channel AXI-Stream sample generator: frames of NUM_PACKETS x PACKET_SIZE beats,
// LANES samples per beat, counter / channel-tagged / LFSR patterns, optional inter-packet gap.
module axis_sample_gen_mc #(
    parameter int DATA_WIDTH   = 128,
    parameter int SAMPLE_WIDTH = 16,
    parameter int NUM_CH       = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                    m_axis_aclk,
    input  logic                    m_axis_areset,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [10:0]             PACKET_SIZE,
    input  logic [7:0]              NUM_PACKETS,
    output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0] M_AXIS_tstrb,
    output logic                    M_AXIS_tlast,
    output logic                    M_AXIS_tuser,
    output logic                    M_AXIS_tvalid,
    input  logic                    M_AXIS_tready,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int LANES  = DATA_WIDTH / SAMPLE_WIDTH;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int GW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [31:0]   LFSR_SEED = 32'hACE1_0001;
    localparam logic [31:0]   LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    // Right-shifting Galois LFSR, one step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ({1'b0, v[31:1]} ^ LFSR_TAPS) : {1'b0, v[31:1]};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] gen_beat(
        input logic [1:0]              m,
        input logic [SAMPLE_WIDTH-1:0] smp,
        input logic [7:0]              pkt,
        input logic [15:0]             lf
    );
        logic [DATA_WIDTH-1:0]   d;
        logic [SAMPLE_WIDTH-1:0] lane;
        logic [3:0]              ch;
        d = {DATA_WIDTH{1'b0}};
        for (int k = 0; k < LANES; k++) begin
            ch = 4'(k % NUM_CH);
            case (m)
                2'b01:   lane = {ch, (SAMPLE_WIDTH-4)'(pkt)};
                2'b10:   lane = SAMPLE_WIDTH'(lf) ^ SAMPLE_WIDTH'(k);
                default: lane = smp + SAMPLE_WIDTH'(k);
            endcase
            d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = lane;
        end
        return d;
    endfunction

    state_t                  state_r, next_state_s;
    logic [1:0]              mode_r;
    logic [10:0]             psize_r, psize_in_s;
    logic [7:0]              npkts_r, npkts_in_s;
    logic [10:0]             beat_cnt_r, nxt_beat_s;
    logic [7:0]              packet_cnt_r, nxt_pkt_s;
    logic [SAMPLE_WIDTH-1:0] sample_cnt_r, nxt_sample_s;
    logic [31:0]             lfsr_r, nxt_lfsr_s;
    logic [GW-1:0]           gap_cnt_r;
    logic                    accept_s, last_beat_s, last_pkt_s;
    logic [DATA_WIDTH-1:0]   tdata_r;
    logic [STRB_W-1:0]       tstrb_r;
    logic                    tvalid_r, tlast_r, tuser_r, frame_done_r, busy_r;

    assign psize_in_s  = (PACKET_SIZE == 11'd0) ? 11'd1 : PACKET_SIZE;
    assign npkts_in_s  = (NUM_PACKETS == 8'd0) ? 8'd1 : NUM_PACKETS;
    assign accept_s    = tvalid_r && M_AXIS_tready;
    assign last_beat_s = (beat_cnt_r == psize_r - 11'd1);
    assign last_pkt_s  = (packet_cnt_r == npkts_r - 8'd1);

    // Frame sequencing: enable is only looked at in IDLE and on the final accepted beat.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (enable) next_state_s = S_LOAD;
                else        next_state_s = S_IDLE;
            end
            S_LOAD: next_state_s = S_STREAM;
            S_STREAM: begin
                if (accept_s && last_beat_s) begin
                    if (last_pkt_s) begin
                        if (enable) next_state_s = S_LOAD;
                        else        next_state_s = S_IDLE;
                    end else if (GAP_CYCLES > 0) begin
                        next_state_s = S_GAP;
                    end else begin
                        next_state_s = S_STREAM;
                    end
                end else begin
                    next_state_s = S_STREAM;
                end
            end
            S_GAP: begin
                if (gap_cnt_r == GAP_LAST) next_state_s = S_STREAM;
                else                       next_state_s = S_GAP;
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Counter values for the beat that will be on the bus next cycle.
    always_comb begin
        nxt_beat_s   = beat_cnt_r;
        nxt_pkt_s    = packet_cnt_r;
        nxt_sample_s = sample_cnt_r;
        nxt_lfsr_s   = lfsr_r;
        if (next_state_s == S_LOAD) begin
            nxt_beat_s   = 11'd0;
            nxt_pkt_s    = 8'd0;
            nxt_sample_s = {SAMPLE_WIDTH{1'b0}};
            nxt_lfsr_s   = LFSR_SEED;
        end else if (accept_s) begin
            nxt_sample_s = sample_cnt_r + SAMPLE_WIDTH'(LANES);
            nxt_lfsr_s   = lfsr_step(lfsr_r);
            if (last_beat_s) begin
                nxt_beat_s = 11'd0;
                nxt_pkt_s  = packet_cnt_r + 8'd1;
            end else begin
                nxt_beat_s = beat_cnt_r + 11'd1;
                nxt_pkt_s  = packet_cnt_r;
            end
        end else begin
            nxt_beat_s = beat_cnt_r;
        end
    end

    // State, counters, latched frame configuration and the registered stream outputs.
    always_ff @(posedge m_axis_aclk) begin
        if (m_axis_areset) begin
            state_r      <= S_IDLE;
            mode_r       <= 2'b00;
            psize_r      <= 11'd1;
            npkts_r      <= 8'd1;
            beat_cnt_r   <= 11'd0;
            packet_cnt_r <= 8'd0;
            sample_cnt_r <= {SAMPLE_WIDTH{1'b0}};
            lfsr_r       <= 32'd0;
            gap_cnt_r    <= {GW{1'b0}};
            tdata_r      <= {DATA_WIDTH{1'b0}};
            tstrb_r      <= {STRB_W{1'b0}};
            tvalid_r     <= 1'b0;
            tlast_r      <= 1'b0;
            tuser_r      <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            beat_cnt_r   <= nxt_beat_s;
            packet_cnt_r <= nxt_pkt_s;
            sample_cnt_r <= nxt_sample_s;
            lfsr_r       <= nxt_lfsr_s;
            if (next_state_s == S_LOAD) begin
                mode_r  <= mode;
                psize_r <= psize_in_s;
                npkts_r <= npkts_in_s;
            end else begin
                mode_r  <= mode_r;
                psize_r <= psize_r;
                npkts_r <= npkts_r;
            end
            if (state_r == S_GAP) gap_cnt_r <= gap_cnt_r + GW'(1);
            else                  gap_cnt_r <= {GW{1'b0}};
            if (next_state_s == S_STREAM) begin
                tdata_r  <= gen_beat(mode_r, nxt_sample_s, nxt_pkt_s, nxt_lfsr_s[15:0]);
                tstrb_r  <= {STRB_W{1'b1}};
                tvalid_r <= 1'b1;
                tlast_r  <= (nxt_beat_s == psize_r - 11'd1);
                tuser_r  <= (nxt_beat_s == 11'd0) && (nxt_pkt_s == 8'd0);
            end else begin
                tdata_r  <= {DATA_WIDTH{1'b0}};
                tstrb_r  <= {STRB_W{1'b0}};
                tvalid_r <= 1'b0;
                tlast_r  <= 1'b0;
                tuser_r  <= 1'b0;
            end
            frame_done_r <= accept_s && last_beat_s && last_pkt_s;
            busy_r       <= (next_state_s != S_IDLE);
        end
    end

    assign M_AXIS_tdata  = tdata_r;
    assign M_AXIS_tstrb  = tstrb_r;
    assign M_AXIS_tvalid = tvalid_r;
    assign M_AXIS_tlast  = tlast_r;
    assign M_AXIS_tuser  = tuser_r;
    assign frame_done    = frame_done_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_axis_sample_gen_mc.sv
// Directed bench for axis_sample_gen_mc: accepted beats are logged on the falling edge,
// stimulus changes just after the rising edge, expected values are hand-computed.
module tb_axis_sample_gen_mc;

    logic         clk = 1'b0;
    logic         areset, enable, tready;
    logic [1:0]   mode;
    logic [10:0]  psize;
    logic [7:0]   npk;
    logic [127:0] tdata;
    logic [15:0]  tstrb;
    logic         tlast, tuser, tvalid, frame_done, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [127:0] dq[$];
    bit           lq[$];
    bit           uq[$];
    int           aq[$];
    int           fq[$];

    axis_sample_gen_mc dut (
        .m_axis_aclk   (clk),
        .m_axis_areset (areset),
        .enable        (enable),
        .mode          (mode),
        .PACKET_SIZE   (psize),
        .NUM_PACKETS   (npk),
        .M_AXIS_tdata  (tdata),
        .M_AXIS_tstrb  (tstrb),
        .M_AXIS_tlast  (tlast),
        .M_AXIS_tuser  (tuser),
        .M_AXIS_tvalid (tvalid),
        .M_AXIS_tready (tready),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Beat/frame_done logger
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (tvalid && tready) begin
                dq.push_back(tdata);
                lq.push_back(tlast);
                uq.push_back(tuser);
                aq.push_back(cyc);
            end
            if (frame_done) fq.push_back(cyc);
        end
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_q();
        dq.delete(); lq.delete(); uq.delete(); aq.delete(); fq.delete();
    endtask

    task automatic start_frame(input logic [1:0] m, input logic [10:0] ps, input logic [7:0] np);
        mode = m; psize = ps; npk = np;
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && fq.size() < n; i++) tick(1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && dq.size() < n; i++) tick(1);
    endtask

    function automatic logic [127:0] beat_at(input int i);
        if (i < dq.size()) return dq[i];
        else               return 128'bx;
    endfunction

    function automatic int last_acc();
        if (aq.size() > 0) return aq[aq.size()-1];
        else               return -100;
    endfunction

    function automatic int count_bits(input bit which_user);
        int c = 0;
        for (int i = 0; i < lq.size(); i++) c += which_user ? int'(uq[i]) : int'(lq[i]);
        return c;
    endfunction

    initial begin
        int frozen;
        areset = 1'b1; enable = 1'b0; tready = 1'b1;
        mode = 2'b00; psize = 11'd16; npk = 8'd1;
        tick(10);
        check_val("rst tvalid", tvalid, 1'b0);
        check_val("rst busy", busy, 1'b0);
        check_val("rst tdata", tdata, 128'd0);
        check_val("rst tstrb", tstrb, 16'd0);
        check_val("rst tlast/tuser/done", {tlast, tuser, frame_done}, 3'b000);
        areset = 1'b0;
        tick(2);

        // T1: single 16-beat packet, counter pattern, latency and frame_done timing
        clear_q();
        mode = 2'b00; psize = 11'd16; npk = 8'd1; enable = 1'b1;
        tick(1);
        check_val("T1 load busy", busy, 1'b1);
        check_val("T1 load tvalid", tvalid, 1'b0);
        enable = 1'b0;
        tick(1);
        check_val("T1 first tvalid", tvalid, 1'b1);
        check_val("T1 first tuser", tuser, 1'b1);
        check_val("T1 first tstrb", tstrb, 16'hFFFF);
        wait_done(1, 200);
        tick(3);
        check_val("T1 beats", dq.size(), 16);
        for (int n = 0; n < dq.size(); n++) begin
            check_val($sformatf("T1 lane0[%0d]", n), dq[n][15:0], 16'(8 * n));
            check_val($sformatf("T1 tlast[%0d]", n), lq[n], (n == 15));
            check_val($sformatf("T1 tuser[%0d]", n), uq[n], (n == 0));
        end
        check_val("T1 lane7 beat3", beat_at(3) >> 112, 128'd31);
        check_val("T1 done pulses", fq.size(), 1);
        check_val("T1 done timing", (fq.size() > 0) ? fq[0] : -1, last_acc() + 1);
        check_val("T1 idle busy", busy, 1'b0);

        // T2: three 4-beat packets, 2-cycle gaps
        clear_q();
        start_frame(2'b00, 11'd4, 8'd3);
        wait_done(1, 200);
        tick(3);
        check_val("T2 beats", dq.size(), 12);
        check_val("T2 tlast count", count_bits(1'b0), 3);
        check_val("T2 tuser count", count_bits(1'b1), 1);
        for (int n = 0; n < dq.size(); n++) begin
            check_val($sformatf("T2 lane0[%0d]", n), dq[n][15:0], 16'(8 * n));
            check_val($sformatf("T2 tlast[%0d]", n), lq[n], (n % 4 == 3));
            if (n > 0) check_val($sformatf("T2 spacing[%0d]", n), aq[n] - aq[n-1], (n % 4 == 0) ? 3 : 1);
        end

        // T3: 20-cycle stall on beat 5
        clear_q();
        start_frame(2'b00, 11'd16, 8'd1);
        wait_beats(5, 100);
        tready = 1'b0;
        frozen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tvalid && tdata[15:0] == 16'd40 && tdata[127:112] == 16'd47 && !tlast && !tuser) frozen++;
        end
        check_val("T3 frozen cycles", frozen, 20);
        check_val("T3 beats during stall", dq.size(), 5);
        tready = 1'b1;
        wait_done(1, 200);
        tick(3);
        check_val("T3 beats", dq.size(), 16);
        for (int n = 0; n < dq.size(); n++)
            check_val($sformatf("T3 lane0[%0d]", n), dq[n][15:0], 16'(8 * n));

        // T4: channel-tagged pattern
        clear_q();
        start_frame(2'b01, 11'd2, 8'd3);
        wait_done(1, 200);
        tick(3);
        check_val("T4 pkt0", beat_at(0), 128'h3000_2000_1000_0000_3000_2000_1000_0000);
        check_val("T4 pkt2 beat0", beat_at(4), 128'h3002_2002_1002_0002_3002_2002_1002_0002);
        check_val("T4 pkt2 beat1", beat_at(5), 128'h3002_2002_1002_0002_3002_2002_1002_0002);

        // LFSR pattern: seed then one Galois step
        clear_q();
        start_frame(2'b10, 11'd2, 8'd1);
        wait_done(1, 200);
        tick(3);
        check_val("LFSR beat0", beat_at(0), 128'h0006_0007_0004_0005_0002_0003_0000_0001);
        check_val("LFSR beat1", beat_at(1), 128'h8004_8005_8006_8007_8000_8001_8002_8003);

        // Zero sizes clamp to 1; reserved mode behaves as counter
        clear_q();
        start_frame(2'b11, 11'd0, 8'd0);
        wait_done(1, 200);
        tick(3);
        check_val("clamp beats", dq.size(), 1);
        check_val("clamp tlast/tuser", {lq.size() > 0 ? lq[0] : 1'b0, uq.size() > 0 ? uq[0] : 1'b0}, 2'b11);
        check_val("mode11 data", beat_at(0), 128'h0007_0006_0005_0004_0003_0002_0001_0000);

        // T5: enable held high across two frames
        clear_q();
        mode = 2'b00; psize = 11'd3; npk = 8'd2; enable = 1'b1;
        wait_beats(7, 200);
        enable = 1'b0;
        wait_done(2, 200);
        tick(3);
        check_val("T5 beats", dq.size(), 12);
        check_val("T5 done pulses", fq.size(), 2);
        check_val("T5 tuser count", count_bits(1'b1), 2);
        check_val("T5 f1 last lane0", beat_at(5) & 128'hFFFF, 128'd40);
        check_val("T5 f2 first lane0", beat_at(6) & 128'hFFFF, 128'd0);
        check_val("T5 f2 tuser", (uq.size() > 6) ? uq[6] : 1'b0, 1'b1);
        check_val("T5 restart spacing", (aq.size() > 6) ? aq[6] - aq[5] : -1, 2);

        // T6: reset mid-frame
        clear_q();
        start_frame(2'b00, 11'd16, 8'd1);
        wait_beats(7, 100);
        areset = 1'b1;
        tick(1);
        check_val("T6 tvalid", tvalid, 1'b0);
        check_val("T6 busy", busy, 1'b0);
        check_val("T6 tdata", tdata, 128'd0);
        areset = 1'b0;
        tick(3);
        check_val("T6 no done", fq.size(), 0);
        check_val("T6 idle tvalid", tvalid, 1'b0);
        clear_q();
        start_frame(2'b00, 11'd16, 8'd1);
        wait_done(1, 200);
        tick(3);
        check_val("T6 beats", dq.size(), 16);
        check_val("T6 first lane0", beat_at(0) & 128'hFFFF, 128'd0);
        check_val("T6 first tuser", (uq.size() > 0) ? uq[0] : 1'b0, 1'b1);
        check_val("T6 last lane0", beat_at(15) & 128'hFFFF, 128'd120);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
